l2_port_arbiter: RTL

Round-robin arbiter that shares one L2 bank request port among `N_REQ` core threads inside a tile. It sits between the per-thread memory request interfaces and a single L2 bank port. It registers the granted request onto the port and caps in-flight requests with a credit counter sized to the bank's MSHR count. Responses are routed back to the originating thread by ID.

---
 rtl/l2_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - round-robin arbiter sharing one L2 bank request port among N_REQ threads
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   req_valid/req_ready            per-thread request handshake (req_ready combinational, one-hot or 0)
//   req_wr/req_addr/req_wdata      per-thread request fields, packed, thread i at [i*W +: W]
//   l2_valid/l2_ready              registered request slot toward the L2 bank
//   l2_wr/l2_addr/l2_wdata/l2_id   registered request fields, l2_id = originating thread
//   l2_rvalid/l2_rid/l2_rdata      L2 responses, one per accepted request
//   resp_valid/resp_data           registered one-hot response strobe and shared data
//   outstanding                    in-flight request count (capped at 2**LOG_MAX_OUT)
//   err_bad_id                     sticky flag for a response with an out-of-range ID
module l2_port_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 34,
  parameter int DATA_W      = 32,
  parameter int LOG_MAX_OUT = 4,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_wr,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic                       l2_valid,
  input  logic                       l2_ready,
  output logic                       l2_wr,
  output logic [ADDR_W-1:0]          l2_addr,
  output logic [DATA_W-1:0]          l2_wdata,
  output logic [ID_W-1:0]            l2_id,
  input  logic                       l2_rvalid,
  input  logic [ID_W-1:0]            l2_rid,
  input  logic [DATA_W-1:0]          l2_rdata,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [LOG_MAX_OUT:0]       outstanding,
  output logic                       err_bad_id
);

  localparam int CNT_W   = LOG_MAX_OUT + 1;
  localparam int MAX_OUT = 1 << LOG_MAX_OUT;

  logic              l2_valid_q, l2_valid_d;
  logic              l2_wr_q, l2_wr_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0] l2_wdata_q, l2_wdata_d;
  logic [ID_W-1:0]   l2_id_q, l2_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              err_q, err_d;

  logic              slot_free;
  logic              can_issue;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              rsp_dec;
  logic              rid_ok;

  // Arbitration: first valid requester at or above rr_q, wrapping.
  // rstn gates issue so nothing is granted while reset is asserted.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    slot_free = !l2_valid_q || l2_ready;
    can_issue = rstn && slot_free && (out_q < CNT_W'(MAX_OUT));
    if (can_issue) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_vld && req_valid[idx]) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
    end
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    l2_valid_d = l2_valid_q;
    l2_wr_d    = l2_wr_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    l2_id_d    = l2_id_q;
    rr_d       = rr_q;
    out_d      = out_q;

    // Slot reloads only when free; a held slot keeps its fields stable.
    if (slot_free) begin
      l2_valid_d = grant_vld;
      if (grant_vld) begin
        l2_wr_d    = req_wr[grant_idx];
        l2_addr_d  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        l2_wdata_d = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
        l2_id_d    = grant_idx;
      end
    end

    if (grant_vld) begin
      rr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end

    // A response with nothing in flight is ignored so the count floors at 0.
    rsp_dec = l2_rvalid && (out_q != '0);
    case ({grant_vld, rsp_dec})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase
  end

  // Response routing: bad IDs are dropped but flagged; data holds otherwise.
  always_comb begin
    rid_ok       = int'(l2_rid) < N_REQ;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = err_q || (l2_rvalid && !rid_ok);
    if (l2_rvalid && rid_ok) begin
      resp_valid_d[l2_rid] = 1'b1;
      resp_data_d          = l2_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      l2_valid_q   <= 1'b0;
      l2_wr_q      <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      l2_id_q      <= '0;
      rr_q         <= '0;
      out_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      l2_valid_q   <= l2_valid_d;
      l2_wr_q      <= l2_wr_d;
      l2_addr_q    <= l2_addr_d;
      l2_wdata_q   <= l2_wdata_d;
      l2_id_q      <= l2_id_d;
      rr_q         <= rr_d;
      out_q        <= out_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign l2_valid    = l2_valid_q;
  assign l2_wr       = l2_wr_q;
  assign l2_addr     = l2_addr_q;
  assign l2_wdata    = l2_wdata_q;
  assign l2_id       = l2_id_q;
  assign outstanding = out_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign err_bad_id  = err_q;

endmodule
